wb_host_bridge: RTL and testbench

// - Upstream Wishbone master for the LFSR peripheral. Turns a slow pin-level host handshake into one

---
 rtl/wb_host_pkg.sv | 13 +
 rtl/wb_host_bridge_sync.sv | 23 ++
 rtl/wb_host_bridge.sv | 104 ++++++++++
 tb/tb_wb_host_bridge.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/wb_host_pkg.sv
// Shared types and default parameters for the pin-level host to Wishbone bridge.
package wb_host_pkg;
  localparam int DEF_AW      = 1;
  localparam int DEF_DW      = 8;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/wb_host_bridge_sync.sv
// Two-flop synchroniser for an asynchronous level plus a delayed copy; emits a one-cycle rise pulse.
module sync_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
endmodule

// File: rtl/wb_host_bridge.sv
// Turns a slow asynchronous host handshake into one single-beat pipelined Wishbone cycle,
// with a bounded wait for ack and a sticky timeout flag.
module wb_host_bridge
  import wb_host_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_busy,
  output logic          host_done,
  output logic          host_err,
  output logic [DW-1:0] host_rdata,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic [DW-1:0] i_wb_data
);
  localparam int          CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          rise, start, active, complete, expire;

  sync_rise u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (host_req),
    .rise  (rise)
  );

  assign start    = rise & (state == IDLE);
  assign active   = (state == REQ) || (state == WAIT);
  assign complete = active & i_wb_ack;
  // Ack on the terminal count wins over the timeout.
  assign expire   = active & ~i_wb_ack & (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Wishbone controls decode straight from the state register, so reset drops them at once.
  always_comb begin
    state_nxt = state;
    o_wb_cyc  = 1'b0;
    o_wb_stb  = 1'b0;
    host_busy = 1'b1;
    host_done = 1'b0;
    case (state)
      IDLE: begin
        host_busy = 1'b0;
        if (start) state_nxt = REQ;
      end
      REQ: begin
        o_wb_cyc = 1'b1;
        o_wb_stb = 1'b1;
        if (i_wb_ack || expire) state_nxt = DONE;
        else if (!i_wb_stall)   state_nxt = WAIT;
      end
      WAIT: begin
        o_wb_cyc = 1'b1;
        if (i_wb_ack || expire) state_nxt = DONE;
      end
      DONE: begin
        host_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_wb_we    <= 1'b0;
      o_wb_addr  <= '0;
      o_wb_data  <= '0;
      host_err   <= 1'b0;
      host_rdata <= '0;
      cnt        <= '0;
    end else if (start) begin
      o_wb_we   <= host_we;
      o_wb_addr <= host_addr;
      o_wb_data <= host_wdata;
      host_err  <= 1'b0;
      cnt       <= '0;
    end else if (active) begin
      if (cnt != CNT_LAST)       cnt        <= cnt + CW'(1);
      if (expire)                host_err   <= 1'b1;
      if (complete && !o_wb_we)  host_rdata <= i_wb_data;
    end
  end
endmodule

// File: tb/tb_wb_host_bridge.sv
// Directed bench: each transaction pushes its expected outcome; a monitor checks on every done pulse.
module tb_wb_host_bridge;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_req = 1'b0, host_we = 1'b0;
  logic [0:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_busy, host_done, host_err;
  logic [7:0] host_rdata;
  logic       o_wb_cyc, o_wb_stb, o_wb_we;
  logic [0:0] o_wb_addr;
  logic [7:0] o_wb_data;
  logic       i_wb_stall = 1'b0, i_wb_ack = 1'b0;
  logic [7:0] i_wb_data = '0;

  wb_host_bridge dut (
    .clk(clk), .rst_n(rst_n), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_busy(host_busy),
    .host_done(host_done), .host_err(host_err), .host_rdata(host_rdata),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .i_wb_stall(i_wb_stall),
    .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [0:0] addr;
    logic [7:0] wdata;
    logic       err;
    logic [7:0] rdata;
    int         nstb;
    int         ncyc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Slave model: stall for the first stall_n cycles of CYC, ack on cycle ack_at.
  int         stall_n = 0, ack_at = 0, k = 0;
  bit         no_ack = 1'b0, force_ack = 1'b0;
  logic       rec_we;
  logic [0:0] rec_addr;
  logic [7:0] rec_data;

  always @(negedge clk) begin
    if (!rst_n || !o_wb_cyc) begin
      k = 0;
      i_wb_stall = 1'b0;
      i_wb_ack = force_ack;
    end else begin
      i_wb_stall = (k < stall_n);
      i_wb_ack = !no_ack && (k == ack_at);
      if (k == 0) begin
        rec_we = o_wb_we; rec_addr = o_wb_addr; rec_data = o_wb_data;
      end
      k++;
    end
  end

  // Monitor: count strobe/cycle beats and check each completion against the queue head.
  int nstb = 0, ncyc = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      nstb = 0; ncyc = 0;
    end else begin
      if (o_wb_stb) nstb++;
      if (o_wb_cyc) ncyc++;
      if (host_done) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: got done pulse want none");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("wb_we", rec_we, e.we);
          chk("wb_addr", rec_addr, e.addr);
          chk("wb_data", rec_data, e.wdata);
          chk("host_err", host_err, e.err);
          chk("host_rdata", host_rdata, e.rdata);
          chk("stb_cycles", nstb, e.nstb);
          chk("cyc_cycles", ncyc, e.ncyc);
        end
        nstb = 0; ncyc = 0;
      end
    end
  end

  task automatic run(input logic we, input logic [0:0] addr, input logic [7:0] wd,
                     input int stall, input int ackat, input bit noack, input logic [7:0] sdata,
                     input logic eerr, input logic [7:0] erd, input int estb, input int ecyc,
                     input bit retrig);
    exp_t e;
    bit got = 1'b0;
    stall_n = stall; ack_at = ackat; no_ack = noack; i_wb_data = sdata;
    e.we = we; e.addr = addr; e.wdata = wd; e.err = eerr; e.rdata = erd;
    e.nstb = estb; e.ncyc = ecyc;
    q.push_back(e);
    host_we = we; host_addr = addr; host_wdata = wd; host_req = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (host_done) got = 1'b1;
      if (retrig && i == 2) host_req = 1'b0;
      if (retrig && i == 5) host_req = 1'b1;
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: got no done pulse want one within 100 cycles");
      void'(q.pop_front());
    end
    host_req = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    bit seen;
    #12;
    chk("rst_cyc", o_wb_cyc, 0);
    chk("rst_stb", o_wb_stb, 0);
    chk("rst_busy", host_busy, 0);
    chk("rst_rdata", host_rdata, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", host_busy, 0);
    chk("idle_done", host_done, 0);

    // we addr wdata stall ackat noack sdata | err rdata stb cyc retrig
    run(0, 1, 8'h00, 0,  0,  0, 8'hA5, 0, 8'hA5, 1,  1,  0); // zero-wait read
    run(1, 0, 8'h3C, 3,  5,  0, 8'h77, 0, 8'hA5, 4,  6,  0); // stalled write
    run(0, 1, 8'h00, 0,  0,  1, 8'hEE, 1, 8'hA5, 1,  15, 0); // timeout in WAIT
    chk("err_sticky", host_err, 1);
    chk("err_idle_busy", host_busy, 0);
    run(0, 1, 8'h00, 0,  14, 0, 8'h5A, 0, 8'h5A, 1,  15, 0); // ack on last cycle
    run(0, 0, 8'h00, 5,  2,  0, 8'hC3, 0, 8'hC3, 3,  3,  0); // ack while stalled
    run(0, 0, 8'h00, 99, 0,  1, 8'h11, 1, 8'hC3, 15, 15, 0); // timeout in REQ
    run(1, 1, 8'h11, 0,  8,  0, 8'h22, 0, 8'hC3, 1,  9,  1); // re-trigger dropped

    // Async reset while in WAIT
    stall_n = 0; no_ack = 1'b1; host_we = 1'b0; host_addr = 1'b1; host_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (o_wb_cyc && !o_wb_stb) seen = 1'b1;
    end
    chk("reached_wait", seen, 1);
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    chk("arst_cyc", o_wb_cyc, 0);
    chk("arst_stb", o_wb_stb, 0);
    chk("arst_busy", host_busy, 0);
    host_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdata", host_rdata, 0);
    chk("post_rst_err", host_err, 0);
    chk("post_rst_we", o_wb_we, 0);
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    force_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_ack_busy", host_busy, 0);
    chk("stray_ack_cyc", o_wb_cyc, 0);

    run(0, 1, 8'h00, 0,  0,  0, 8'h96, 0, 8'h96, 1,  1,  0); // normal after reset

    chk("pending_expectations", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
